// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch-side program counter owner. Issues instruction requests to the
// I-cache, forwards each returned instruction (with its PC) to the decoder, and
// stalls fetch after every control-transfer instruction until the branch unit
// delivers the resolved next PC.
//
// Optional feature macro: FETCH_JAL_EN
//   defined   : JAL is resolved locally (PC += J-immediate), no branch wait
//   undefined : JAL waits for BranchResultEn like JALR
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   rdy            in   global enable, 0 freezes all state
//   BranchResultEn in   resolved target valid this cycle
//   BranchAddr     in   resolved next PC (low two bits ignored)
//   FetchEn        out  I-cache request valid
//   FetchAddr      out  I-cache request address
//   InstValid      in   I-cache reply valid for FetchAddr
//   Inst           in   fetched instruction
//   DecoderStall   in   decoder cannot accept this cycle
//   InstOutEn      out  one-cycle pulse, InstOut/InstPC valid
//   InstOut        out  instruction to decoder
//   InstPC         out  PC of InstOut
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FETCH       | request outstanding at PC, waiting for an I-cache reply
// HOLD        | reply captured in hold buffer, decoder is stalled
// WAIT_BRANCH | control transfer forwarded, waiting for resolved target
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              BranchResultEn,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              FetchEn,
  output logic [ADDR_W-1:0] FetchAddr,
  input  logic              InstValid,
  input  logic [INST_W-1:0] Inst,
  input  logic              DecoderStall,
  output logic              InstOutEn,
  output logic [INST_W-1:0] InstOut,
  output logic [ADDR_W-1:0] InstPC
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH       = 2'd0,
    HOLD        = 2'd1,
    WAIT_BRANCH = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                fetch_en_q;
  logic                inst_out_en_q;
  logic [INST_W-1:0]   inst_out_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic [INST_W-1:0]   hold_q;

  // Instruction being handed to the decoder this cycle (if issue is set)
  logic [INST_W-1:0]   issue_inst;
  logic                issue;
  logic                ctrl_xfer;
  logic [ADDR_W-1:0]   pc_seq_d;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  logic                unused_branch_lo;
  assign unused_branch_lo = ^BranchAddr[1:0];

  always_comb begin
    issue_inst = (state_q == HOLD) ? hold_q : Inst;

    issue = 1'b0;
    case (state_q)
      FETCH:   issue = fetch_en_q && InstValid && !DecoderStall;
      HOLD:    issue = !DecoderStall;
      default: issue = 1'b0;
    endcase

    ctrl_xfer = 1'b0;
    if ((issue_inst[6:0] == OP_BRANCH) || (issue_inst[6:0] == OP_JALR)) begin
      ctrl_xfer = 1'b1;
    end
`ifndef FETCH_JAL_EN
    if (issue_inst[6:0] == OP_JAL) begin
      ctrl_xfer = 1'b1;
    end
`endif

    pc_seq_d = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
`ifdef FETCH_JAL_EN
    // JAL target is fully known from the encoding, so resolve it here
    if (issue_inst[6:0] == OP_JAL) begin
      pc_seq_d = pc_q + {{(ADDR_W-21){issue_inst[31]}},
                         issue_inst[31], issue_inst[19:12], issue_inst[20],
                         issue_inst[30:21], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      fetch_en_q    <= 1'b0;
      inst_out_en_q <= 1'b0;
      inst_out_q    <= '0;
      inst_pc_q     <= '0;
      hold_q        <= '0;
    end else if (rdy) begin
      inst_out_en_q <= 1'b0;
      if (issue) begin
        inst_out_en_q <= 1'b1;
        inst_out_q    <= issue_inst;
        inst_pc_q     <= pc_q;
      end

      case (state_q)
        FETCH: begin
          if (fetch_en_q && InstValid && DecoderStall) begin
            hold_q     <= Inst;
            state_q    <= HOLD;
            fetch_en_q <= 1'b0;
          end else if (issue && ctrl_xfer) begin
            state_q    <= WAIT_BRANCH;
            fetch_en_q <= 1'b0;
          end else begin
            if (issue) begin
              pc_q <= pc_seq_d;
            end
            // Also raises the first request after reset release
            fetch_en_q <= 1'b1;
          end
        end

        HOLD: begin
          if (issue) begin
            if (ctrl_xfer) begin
              state_q <= WAIT_BRANCH;
            end else begin
              pc_q       <= pc_seq_d;
              state_q    <= FETCH;
              fetch_en_q <= 1'b1;
            end
          end
        end

        WAIT_BRANCH: begin
          if (BranchResultEn) begin
            pc_q       <= {BranchAddr[ADDR_W-1:2], 2'b00};
            state_q    <= FETCH;
            fetch_en_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= FETCH;
          fetch_en_q <= 1'b0;
        end
      endcase
    end
  end

  // rdy gates the strobes combinationally so a frozen pipeline never handshakes
  assign FetchEn   = fetch_en_q & rdy;
  assign FetchAddr = pc_q;
  assign InstOutEn = inst_out_en_q & rdy;
  assign InstOut   = inst_out_q;
  assign InstPC    = inst_pc_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-side consumer of the branch unit's resolution result (BranchResultEn/BranchAddr).
- Owns the architectural PC and drives instruction requests to the I-cache. It forwards fetched instructions with their PC to the decoder.
- Stalls fetch after every control-transfer instruction until the branch unit returns the resolved target. Sits between the I-cache, the decoder and the branch unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, width of all instruction addresses (matches `InstAddrBus).
- INST_W, 32, instruction width (matches `InstBus).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when 0 all state freezes.
- BranchResultEn  in  1  branch unit has a resolved target this cycle.
- BranchAddr  in  ADDR_W  resolved next PC (taken target or PC+4).
- FetchEn  out  1  I-cache request valid.
- FetchAddr  out  ADDR_W  I-cache request address.
- InstValid  in  1  I-cache returns Inst for FetchAddr this cycle.
- Inst  in  INST_W  fetched instruction.
- DecoderStall  in  1  decoder cannot accept an instruction this cycle.
- InstOutEn  out  1  one-cycle pulse: InstOut/InstPC valid to decoder.
- InstOut  out  INST_W  instruction to decoder.
- InstPC  out  ADDR_W  PC of InstOut.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=FETCH, PC=RESET_PC.
  - FetchEn=0, FetchAddr=RESET_PC.
  - InstOutEn=0, InstOut=0, InstPC=0.
  - Holding buffer cleared.
  - Reset wins over every other input, including mid-fetch and in WAIT_BRANCH; a pending I-cache reply is discarded.
- rdy=0: no register updates. InstOutEn and FetchEn are gated to 0 combinationally while rdy=0.
- All outputs are registered. FetchEn=1 exactly when state==FETCH (first asserted the cycle after reset release), with FetchAddr=PC.
- InstValid is honoured only when FetchEn=1; otherwise it is ignored.
- Control classification on Inst[6:0]:
  - 1100011 (branch) and 1100111 (JALR) are control.
  - 1101111 (JAL) is control unless FETCH_JAL_EN.
  - All other opcodes are sequential.
- FETCH:
  - InstValid=1, DecoderStall=0:
    - Next cycle InstOutEn=1, InstOut=Inst, InstPC=PC.
    - Sequential: PC<=PC+4 (mod 2^32 wrap), stay FETCH. Back-to-back fetch, one instruction per I-cache reply.
    - Control: state<=WAIT_BRANCH, FetchEn<=0.
  - InstValid=1, DecoderStall=1: latch Inst into the holding buffer, state<=HOLD, FetchEn<=0.
  - InstValid=0: hold FetchEn/FetchAddr unchanged.
- HOLD:
  - While DecoderStall=1: nothing is emitted.
  - First cycle DecoderStall=0: emit the held instruction (next cycle InstOutEn=1, InstPC=PC), then apply the same sequential/control rule as FETCH.
- WAIT_BRANCH:
  - BranchResultEn=1: PC<={BranchAddr[ADDR_W-1:2],2'b00} (low bits forced to 0), state<=FETCH. FetchEn=1 with the new address on the next cycle, giving a one-cycle redirect latency.
- BranchResultEn in FETCH or HOLD is ignored; the bench flags it as a protocol error.
- InstOutEn never asserts two consecutive cycles for the same instruction. Exactly one pulse is produced per accepted InstValid.

Optional Feature:
- Macro: FETCH_JAL_EN.
- Defined: JAL is treated as sequential for fetch. PC<=PC+sext({Inst[31],Inst[19:12],Inst[20],Inst[30:21],1'b0}) and state stays FETCH, avoiding the WAIT_BRANCH stall. The JAL is still forwarded to the decoder.
- Undefined: JAL enters WAIT_BRANCH like JALR and redirects only on BranchResultEn.

Test Plan:
- Reset then 3 sequential ADDI replies, each 1 cycle after request -> FetchAddr 0x0,0x4,0x8; InstOutEn pulses with InstPC 0x0,0x4,0x8.
- BEQ at 0x10, BranchResultEn=1 with BranchAddr=0x40 after 5 cycles -> FetchEn=0 during wait; next FetchAddr=0x40; no InstOutEn during wait.
- DecoderStall=1 for 4 cycles when InstValid at 0x8 -> single InstOutEn with InstPC=0x8 the cycle after stall drops; next FetchAddr=0xC.
- JALR at 0x20, BranchAddr=0x103 -> next FetchAddr=0x100.
- rst=1 in WAIT_BRANCH, then stale BranchResultEn -> FetchAddr=RESET_PC, BranchResultEn ignored.
- JAL imm=+0x80 at 0x30 -> with FETCH_JAL_EN next FetchAddr=0xB0 immediately; without it, waits for BranchResultEn.
